// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : Y86 execute stage: ALU, condition evaluation, cmov dstE gating, CC register.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int STACK_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ex_icode,
  input  logic [7:0]        ex_ifun,
  input  logic [DATA_W-1:0] ex_valA,
  input  logic [DATA_W-1:0] ex_valB,
  input  logic [DATA_W-1:0] ex_valC,
  input  logic [7:0]        ex_dstE,
  input  logic              M_exc_i,
  input  logic              W_exc_i,
  output logic [DATA_W-1:0] ex_valE_o,
  output logic              ex_Cnd_o,
  output logic [7:0]        ex_dstE_o,
  output logic [2:0]        cc_o
);

  localparam logic [7:0] c_INOP    = 8'h01;
  localparam logic [7:0] c_IRRMOVL = 8'h02;
  localparam logic [7:0] c_IIRMOVL = 8'h03;
  localparam logic [7:0] c_IRMMOVL = 8'h04;
  localparam logic [7:0] c_IMRMOVL = 8'h05;
  localparam logic [7:0] c_IOPL    = 8'h06;
  localparam logic [7:0] c_IJXX    = 8'h07;
  localparam logic [7:0] c_ICALL   = 8'h08;
  localparam logic [7:0] c_IRET    = 8'h09;
  localparam logic [7:0] c_IPUSHL  = 8'h0A;
  localparam logic [7:0] c_IPOPL   = 8'h0B;
  localparam logic [7:0] c_RNONE   = 8'h0F;
  localparam logic       c_ENABLE  = 1'b1;

  localparam logic [3:0] c_ALUADD = 4'h0;
  localparam logic [3:0] c_ALUSUB = 4'h1;
  localparam logic [3:0] c_ALUAND = 4'h2;
  localparam logic [3:0] c_ALUXOR = 4'h3;

  localparam logic [DATA_W-1:0] c_STEP = DATA_W'(STACK_STEP);

  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [3:0]        w_alufun;
  logic [DATA_W-1:0] w_vale;
  logic              w_of;
  logic              w_zf;
  logic              w_sf;
  logic              w_set_cc;
  logic              w_cnd_raw;
  logic              w_cnd;
  logic [2:0]        r_cc;

  always_comb begin
    w_alu_a = '0;
    unique case (ex_icode)
      c_IRRMOVL, c_IOPL:              w_alu_a = ex_valA;
      c_IIRMOVL, c_IRMMOVL, c_IMRMOVL: w_alu_a = ex_valC;
      c_ICALL, c_IPUSHL:              w_alu_a = '0 - c_STEP;
      c_IRET, c_IPOPL:                w_alu_a = c_STEP;
      default:                        w_alu_a = '0;
    endcase
  end

  always_comb begin
    w_alu_b = '0;
    unique case (ex_icode)
      c_IRMMOVL, c_IMRMOVL, c_IOPL, c_ICALL, c_IPUSHL, c_IRET, c_IPOPL: w_alu_b = ex_valB;
      default: w_alu_b = '0;
    endcase
  end

  assign w_alufun = (ex_icode == c_IOPL) ? ex_ifun[3:0] : c_ALUADD;

  // Unsupported OPL functions yield zero but still update flags.
  always_comb begin
    w_vale = '0;
    w_of   = 1'b0;
    unique case (w_alufun)
      c_ALUADD: begin
        w_vale = w_alu_b + w_alu_a;
        w_of   = (w_alu_a[DATA_W-1] == w_alu_b[DATA_W-1]) && (w_vale[DATA_W-1] != w_alu_a[DATA_W-1]);
      end
      c_ALUSUB: begin
        w_vale = w_alu_b - w_alu_a;
        w_of   = (w_alu_a[DATA_W-1] != w_alu_b[DATA_W-1]) && (w_vale[DATA_W-1] != w_alu_b[DATA_W-1]);
      end
      c_ALUAND: w_vale = w_alu_b & w_alu_a;
      c_ALUXOR: w_vale = w_alu_b ^ w_alu_a;
      default: begin
        w_vale = '0;
        w_of   = 1'b0;
      end
    endcase
  end

  assign w_zf     = (w_vale == '0);
  assign w_sf     = w_vale[DATA_W-1];
  assign w_set_cc = (ex_icode == c_IOPL) && (M_exc_i != c_ENABLE) && (W_exc_i != c_ENABLE);

  always_ff @(posedge clk) begin
    if (!rst)
      r_cc <= 3'b100;
    else if (w_set_cc)
      r_cc <= {w_zf, w_sf, w_of};
  end

  // Condition is evaluated against CC as it stood before this cycle's update.
  always_comb begin
    w_cnd_raw = 1'b0;
    unique case (ex_ifun)
      8'd0:    w_cnd_raw = 1'b1;
      8'd1:    w_cnd_raw = (r_cc[1] ^ r_cc[0]) | r_cc[2];
      8'd2:    w_cnd_raw = r_cc[1] ^ r_cc[0];
      8'd3:    w_cnd_raw = r_cc[2];
      8'd4:    w_cnd_raw = ~r_cc[2];
      8'd5:    w_cnd_raw = ~(r_cc[1] ^ r_cc[0]);
      8'd6:    w_cnd_raw = ~(r_cc[1] ^ r_cc[0]) & ~r_cc[2];
      default: w_cnd_raw = 1'b0;
    endcase
  end

  assign w_cnd = ((ex_icode == c_IJXX) || (ex_icode == c_IRRMOVL)) ? w_cnd_raw : 1'b0;

  assign ex_valE_o = w_vale;
  assign ex_Cnd_o  = w_cnd;
  assign ex_dstE_o = ((ex_icode == c_IRRMOVL) && !w_cnd) ? c_RNONE : ex_dstE;
  assign cc_o      = r_cc;

  // c_INOP is listed for completeness; bubbles fall through the defaults above.
  logic w_unused;
  assign w_unused = (ex_icode == c_INOP);

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Directed-vector scoreboard bench for ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  ex_icode;
  logic [7:0]  ex_ifun;
  logic [31:0] ex_valA;
  logic [31:0] ex_valB;
  logic [31:0] ex_valC;
  logic [7:0]  ex_dstE;
  logic        M_exc_i;
  logic        W_exc_i;
  logic [31:0] ex_valE_o;
  logic        ex_Cnd_o;
  logic [7:0]  ex_dstE_o;
  logic [2:0]  cc_o;

  typedef struct {
    int          id;
    logic [31:0] vale;
    logic        cnd;
    logic [7:0]  dste;
    logic [2:0]  cc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  ex_stage #(.DATA_W(32), .STACK_STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_icode  (ex_icode),
    .ex_ifun   (ex_ifun),
    .ex_valA   (ex_valA),
    .ex_valB   (ex_valB),
    .ex_valC   (ex_valC),
    .ex_dstE   (ex_dstE),
    .M_exc_i   (M_exc_i),
    .W_exc_i   (W_exc_i),
    .ex_valE_o (ex_valE_o),
    .ex_Cnd_o  (ex_Cnd_o),
    .ex_dstE_o (ex_dstE_o),
    .cc_o      (cc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so each issued vector is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (ex_valE_o !== e.vale) begin
        failures++;
        $display("FAIL v%0d valE: got %h expected %h", e.id, ex_valE_o, e.vale);
      end
      checks++;
      if (ex_Cnd_o !== e.cnd) begin
        failures++;
        $display("FAIL v%0d Cnd: got %b expected %b", e.id, ex_Cnd_o, e.cnd);
      end
      checks++;
      if (ex_dstE_o !== e.dste) begin
        failures++;
        $display("FAIL v%0d dstE: got %h expected %h", e.id, ex_dstE_o, e.dste);
      end
      checks++;
      if (cc_o !== e.cc) begin
        failures++;
        $display("FAIL v%0d cc: got %b expected %b", e.id, cc_o, e.cc);
      end
    end
  end

  int vid = 0;

  task automatic issue(input logic r, input logic [7:0] icode, input logic [7:0] ifun,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [7:0] dst, input logic mexc, input logic wexc,
                       input logic [31:0] x_vale, input logic x_cnd,
                       input logic [7:0] x_dste, input logic [2:0] x_cc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_icode = icode; ex_ifun = ifun;
    ex_valA = a; ex_valB = b; ex_valC = c; ex_dstE = dst;
    M_exc_i = mexc; W_exc_i = wexc;
    e.id = vid; e.vale = x_vale; e.cnd = x_cnd; e.dste = x_dste; e.cc = x_cc;
    sb.push_back(e);
    vid++;
  endtask

  initial begin
    rst = 1'b0; ex_icode = 8'h01; ex_ifun = 8'h00;
    ex_valA = '0; ex_valB = '0; ex_valC = '0; ex_dstE = 8'h0F;
    M_exc_i = 1'b0; W_exc_i = 1'b0;
    @(posedge clk);
    //     rst icode  ifun   valA          valB          valC      dst    M     W     valE          Cnd   dstE   cc
    issue(1, 8'h01, 8'h00, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b100);
    issue(1, 8'h06, 8'h01, 32'd5,        32'd5,        32'h0,    8'h02, 1'b0, 1'b0, 32'h0,        1'b0, 8'h02, 3'b100);
    issue(1, 8'h01, 8'h00, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b100);
    issue(1, 8'h06, 8'h00, 32'd1,        32'h7FFFFFFF, 32'h0,    8'h01, 1'b0, 1'b0, 32'h80000000, 1'b0, 8'h01, 3'b100);
    issue(1, 8'h07, 8'h02, 32'h0,        32'h0,        32'h40,   8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b011);
    issue(1, 8'h06, 8'h00, 32'd1,        32'd1,        32'h0,    8'h01, 1'b0, 1'b0, 32'd2,        1'b0, 8'h01, 3'b011);
    issue(1, 8'h02, 8'h02, 32'h55,       32'h0,        32'h0,    8'h03, 1'b0, 1'b0, 32'h55,       1'b0, 8'h0F, 3'b000);
    issue(1, 8'h06, 8'h00, 32'h80000000, 32'h0,        32'h0,    8'h01, 1'b0, 1'b0, 32'h80000000, 1'b0, 8'h01, 3'b000);
    issue(1, 8'h02, 8'h02, 32'h55,       32'h0,        32'h0,    8'h03, 1'b0, 1'b0, 32'h55,       1'b1, 8'h03, 3'b010);
    issue(1, 8'h06, 8'h03, 32'hF0,       32'hFF,       32'h0,    8'h01, 1'b1, 1'b0, 32'h0F,       1'b0, 8'h01, 3'b010);
    issue(1, 8'h06, 8'h03, 32'hFF,       32'hFF,       32'h0,    8'h01, 1'b0, 1'b1, 32'h0,        1'b0, 8'h01, 3'b010);
    issue(1, 8'h01, 8'h00, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b010);
    issue(1, 8'h0A, 8'h00, 32'h7,        32'h100,      32'h0,    8'h04, 1'b0, 1'b0, 32'hFC,       1'b0, 8'h04, 3'b010);
    issue(0, 8'h06, 8'h00, 32'd1,        32'd1,        32'h0,    8'h01, 1'b0, 1'b0, 32'd2,        1'b0, 8'h01, 3'b010);
    issue(1, 8'h01, 8'h00, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b100);
    issue(1, 8'h06, 8'h02, 32'hF0F0,     32'hFF00,     32'h0,    8'h01, 1'b0, 1'b0, 32'hF000,     1'b0, 8'h01, 3'b100);
    issue(1, 8'h06, 8'h01, 32'd1,        32'h80000000, 32'h0,    8'h01, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 8'h01, 3'b000);
    issue(1, 8'h07, 8'h05, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b001);
    issue(1, 8'h07, 8'h04, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b1, 8'h0F, 3'b001);
    issue(1, 8'h07, 8'h06, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b001);
    issue(1, 8'h07, 8'h00, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b1, 8'h0F, 3'b001);
    issue(1, 8'h07, 8'h07, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b001);
    issue(1, 8'h09, 8'h00, 32'h0,        32'h100,      32'h0,    8'h04, 1'b0, 1'b0, 32'h104,      1'b0, 8'h04, 3'b001);
    issue(1, 8'h03, 8'h00, 32'h99,       32'h77,       32'h1234, 8'h05, 1'b0, 1'b0, 32'h1234,     1'b0, 8'h05, 3'b001);
    issue(1, 8'h05, 8'h00, 32'h99,       32'h20,       32'd8,    8'h06, 1'b0, 1'b0, 32'h28,       1'b0, 8'h06, 3'b001);
    issue(1, 8'h06, 8'h05, 32'd3,        32'd4,        32'h0,    8'h01, 1'b0, 1'b0, 32'h0,        1'b0, 8'h01, 3'b001);
    issue(1, 8'h01, 8'h00, 32'h0,        32'h0,        32'h0,    8'h0F, 1'b0, 1'b0, 32'h0,        1'b0, 8'h0F, 3'b100);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
